// File: rtl/uart_stream_tx.sv
`timescale 1ns/1ps
// uart_stream_tx: buffered 8N1 UART transmitter.
// Bytes arrive on a valid/ready stream into a small circular FIFO and are
// serialised start / 8 data bits LSB-first / stop. Bit timing is derived
// from CLOCK_RATE/BAUD_RATE in the system clock domain. The tx pin is driven
// from a flop one cycle behind the FSM, so every bit lasts exactly BIT_TICKS.
module uart_stream_tx #(
    parameter int BAUD_RATE  = 115200,
    parameter int CLOCK_RATE = 12000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic [7:0]                  data,
    input  logic                        valid,
    output logic                        ready,
    output logic                        tx,
    output logic                        idle,
    output logic [$clog2(FIFO_DEPTH):0] fifoCount
);

    localparam int BIT_TICKS = CLOCK_RATE / BAUD_RATE;
    localparam int TICK_W    = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int IDX_W     = $clog2(FIFO_DEPTH);
    localparam int PTR_W     = IDX_W + 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [PTR_W-1:0]  FIFO_FULL = PTR_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // FIFO storage and status
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [PTR_W-1:0] count_r;
    logic [PTR_W-1:0] count_nxt_s;
    logic             fifo_empty_s;
    logic             push_s;
    logic             pop_s;

    // Serialiser
    state_t           state_r;
    state_t           state_nxt_s;
    logic [TICK_W-1:0] tick_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             tick_last_s;
    logic             tx_nxt_s;

    // Output flops
    logic             tx_r;
    logic             ready_r;
    logic             idle_r;

    assign push_s       = valid && ready_r;
    assign fifo_empty_s = (count_r == PTR_W'(0));
    assign tick_last_s  = (tick_cnt_r == TICK_LAST);

    assign ready     = ready_r;
    assign tx        = tx_r;
    assign idle      = idle_r;
    assign fifoCount = count_r;

    // Next FIFO pointers and occupancy from this cycle's push/pop decisions
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    end

    // FIFO pointers, occupancy and ready; ready depends only on flops
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= PTR_W'(0);
            ready_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            ready_r  <= (count_nxt_s != FIFO_FULL);
        end
    end

    // FIFO storage write; contents are don't-care until the pointers cover them
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[IDX_W-1:0]] <= data;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: STOP chains straight into START when more bytes wait
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_last_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_last_s && (bit_cnt_r == 3'd7)) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_last_s) begin
                    if (!fifo_empty_s) begin
                        state_nxt_s = ST_START;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: FIFO pop strobe and the line level for the current bit
    always_comb begin
        pop_s    = 1'b0;
        tx_nxt_s = 1'b1;
        case (state_r)
            ST_IDLE: begin
                pop_s    = !fifo_empty_s;
                tx_nxt_s = 1'b1;
            end
            ST_START: begin
                pop_s    = 1'b0;
                tx_nxt_s = 1'b0;
            end
            ST_DATA: begin
                pop_s    = 1'b0;
                tx_nxt_s = shift_r[bit_cnt_r];
            end
            ST_STOP: begin
                if (tick_last_s) begin
                    pop_s = !fifo_empty_s;
                end else begin
                    pop_s = 1'b0;
                end
                tx_nxt_s = 1'b1;
            end
            default: begin
                pop_s    = 1'b0;
                tx_nxt_s = 1'b1;
            end
        endcase
    end

    // Tick and bit counters; both return to 0 only by explicit reload
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            tick_cnt_r <= TICK_W'(0);
            bit_cnt_r  <= 3'd0;
        end else begin
            if ((state_r == ST_IDLE) || tick_last_s) begin
                tick_cnt_r <= TICK_W'(0);
            end else begin
                tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            end
            if (state_r != ST_DATA) begin
                bit_cnt_r <= 3'd0;
            end else if (tick_last_s) begin
                bit_cnt_r <= (bit_cnt_r == 3'd7) ? 3'd0 : (bit_cnt_r + 3'd1);
            end
        end
    end

    // Shift register captures the FIFO head on pop and holds it for the frame
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            shift_r <= 8'h00;
        end else if (pop_s) begin
            shift_r <= mem_r[rd_ptr_r[IDX_W-1:0]];
        end
    end

    // Registered line driver and idle flag; reset forces the line high at once
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            tx_r   <= 1'b1;
            idle_r <= 1'b1;
        end else begin
            tx_r   <= tx_nxt_s;
            idle_r <= (state_nxt_s == ST_IDLE) && (count_nxt_s == PTR_W'(0));
        end
    end

endmodule

// File: tb/tb_uart_stream_tx.sv
`timescale 1ns/1ps
// Bench for uart_stream_tx: directed scenarios plus random bytes, with a line
// monitor that rebuilds each expected 8N1 waveform from the accepted bytes.
module tb_uart_stream_tx;

    localparam int CLOCK_RATE = 8000;
    localparam int BAUD_RATE  = 1000;
    localparam int FIFO_DEPTH = 4;
    localparam int BT         = CLOCK_RATE / BAUD_RATE;
    localparam int FRAME      = 10 * BT;

    logic       clk = 1'b0;
    logic       rstN;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       idle;
    logic [2:0] fifoCount;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];
    int         frames_done = 0;
    int         samp_cnt    = 0;
    bit         in_frame    = 1'b0;
    int         fpos        = 0;
    bit         frame_bad   = 1'b0;
    logic [7:0] cur_byte    = 8'h00;
    logic [7:0] rx_byte     = 8'h00;
    logic       exp_bit;
    bit         noisy;

    always #5 clk = ~clk;

    uart_stream_tx #(
        .BAUD_RATE (BAUD_RATE),
        .CLOCK_RATE(CLOCK_RATE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rstN     (rstN),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .tx       (tx),
        .idle     (idle),
        .fifoCount(fifoCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Ideal line level at sample position pos (0..FRAME-1) of a frame carrying b
    function automatic logic line_bit(input logic [7:0] b, input int pos);
        int slot;
        slot = pos / BT;
        if (slot == 0) return 1'b0;
        else if (slot <= 8) return b[slot-1];
        else return 1'b1;
    endfunction

    // Offer one byte, waiting (bounded) for ready; returns just after the accept edge
    task automatic offer(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        data  = b;
        valid = 1'b1;
        while (ready !== 1'b1 && guard < 4 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        if (ready !== 1'b1) chk("offer_timeout", 32'(ready), 32'd1);
        @(posedge clk);
        exp_q.push_back(b);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(idle === 1'b1 && !in_frame) && guard < 20 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_timeout", 32'(guard < 20 * FRAME), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Line monitor: on each start bit, compare every sample of the frame
    initial begin : monitor
        forever begin
            @(negedge clk);
            samp_cnt++;
            if (rstN !== 1'b1) begin
                in_frame = 1'b0;
            end else if (in_frame) begin
                exp_bit = line_bit(cur_byte, fpos);
                if (tx !== exp_bit) frame_bad = 1'b1;
                if ((fpos % BT) == BT / 2 && fpos / BT >= 1 && fpos / BT <= 8)
                    rx_byte[fpos / BT - 1] = tx;
                fpos++;
                if (fpos == FRAME) begin
                    chk("frame_wave", 32'(frame_bad), 32'd0);
                    chk("frame_byte", 32'(rx_byte), 32'(cur_byte));
                    frames_done++;
                    in_frame = 1'b0;
                end
            end else if (tx === 1'b0) begin
                start_q.push_back(samp_cnt);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'(exp_q.size()), 32'd1);
                    cur_byte = 8'h00;
                end else begin
                    cur_byte = exp_q.pop_front();
                end
                in_frame  = 1'b1;
                fpos      = 1;
                frame_bad = 1'b0;
                rx_byte   = 8'h00;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rstN  = 1'b0;
        data  = 8'h00;
        valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx",    32'(tx),        32'd1);
        chk("rst_ready", 32'(ready),     32'd1);
        chk("rst_idle",  32'(idle),      32'd1);
        chk("rst_count", 32'(fifoCount), 32'd0);
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte latency and idle timing
        offer(8'hA5);
        @(negedge clk);
        valid = 1'b0;
        chk("t1_idle_drop", 32'(idle),      32'd0);
        chk("t1_count1",    32'(fifoCount), 32'd1);
        chk("t1_tx_n",      32'(tx),        32'd1);
        @(negedge clk);
        chk("t1_count_pop", 32'(fifoCount), 32'd0);
        chk("t1_tx_n1",     32'(tx),        32'd1);
        @(negedge clk);
        chk("t1_tx_start",  32'(tx),        32'd0);
        repeat (78) @(negedge clk);
        chk("t1_idle_busy", 32'(idle),      32'd0);
        @(negedge clk);
        chk("t1_idle_back", 32'(idle),      32'd1);
        wait_idle();
        chk("t1_frames", 32'(frames_done), 32'd1);

        // Burst of five: FIFO fills, ready returns at first frame end
        start_q.delete();
        offer(8'h00);
        offer(8'hFF);
        offer(8'h55);
        offer(8'h3C);
        offer(8'h81);
        @(negedge clk);
        valid = 1'b0;
        chk("t2_ready_full", 32'(ready),     32'd0);
        chk("t2_count4",     32'(fifoCount), 32'd4);
        repeat (76) @(negedge clk);
        chk("t2_ready_held", 32'(ready),     32'd0);
        @(negedge clk);
        chk("t2_ready_back", 32'(ready),     32'd1);
        chk("t2_count3",     32'(fifoCount), 32'd3);
        wait_idle();
        chk("t2_frames", 32'(frames_done), 32'd6);
        chk("t2_starts", 32'(start_q.size()), 32'd5);
        for (int i = 1; i < 5; i++)
            chk("t2_gap", 32'(start_q[i] - start_q[i-1]), 32'(FRAME));

        // Push on the same edge the stop bit ends and the next byte pops
        start_q.delete();
        offer(8'hC3);
        offer(8'h5A);
        @(negedge clk);
        valid = 1'b0;
        chk("t3_count_pp", 32'(fifoCount), 32'd1);
        repeat (79) @(negedge clk);
        chk("t3_count_pre", 32'(fifoCount), 32'd1);
        data  = 8'h96;
        valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(8'h96);
        @(negedge clk);
        valid = 1'b0;
        chk("t3_count_same", 32'(fifoCount), 32'd1);
        wait_idle();
        chk("t3_frames", 32'(frames_done), 32'd9);
        chk("t3_starts", 32'(start_q.size()), 32'd3);
        for (int i = 1; i < 3; i++)
            chk("t3_gap", 32'(start_q[i] - start_q[i-1]), 32'(FRAME));

        // Reset during data bit 3 of 0x0F with two bytes queued
        offer(8'h0F);
        offer(8'h11);
        offer(8'h22);
        @(negedge clk);
        valid = 1'b0;
        repeat (34) @(negedge clk);
        chk("t4_count_pre", 32'(fifoCount), 32'd2);
        chk("t4_tx_bit3",   32'(tx),        32'd1);
        #2 rstN = 1'b0;
        #1;
        chk("t4_tx_async",    32'(tx),        32'd1);
        chk("t4_count_async", 32'(fifoCount), 32'd0);
        chk("t4_ready_async", 32'(ready),     32'd1);
        chk("t4_idle_async",  32'(idle),      32'd1);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        exp_q.delete();
        noisy = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || idle !== 1'b1) noisy = 1'b1;
        end
        chk("t4_quiet",  32'(noisy),       32'd0);
        chk("t4_frames", 32'(frames_done), 32'd9);

        // Data bus churn during a frame must not disturb the shifted byte
        offer(8'($urandom));
        @(negedge clk);
        valid = 1'b0;
        repeat (FRAME + 4) begin
            data = 8'($urandom);
            @(negedge clk);
        end
        wait_idle();
        chk("t5_frames", 32'(frames_done), 32'd10);

        // 100 random bytes with random producer gaps
        for (int i = 0; i < 100; i++) begin
            offer(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                valid = 1'b0;
                repeat ($urandom_range(1, 120)) @(negedge clk);
            end
        end
        @(negedge clk);
        valid = 1'b0;
        wait_idle();
        chk("t6_frames", 32'(frames_done),  32'd110);
        chk("t6_queue",  32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
